uart_tx_arbiter: RTL

- Shares one UART_TX transmitter between NUM_REQ byte requesters using round-robin arbitration.
- Accepts a byte and parity select per requester over a valid/ready handshake, and pulses tx_start to the transmitter.
- Holds the transmitter's data and parity inputs stable for the whole frame, then waits for tx_done before granting again.
- Sits between the AHB UART register/FIFO logic and UART_TX.

---
 rtl/uart_tx_arb_pkg.sv | 15 +
 rtl/uart_tx_arbiter_rr.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART TX round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_tx_arb_pkg;

  localparam int DATA_W                 = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 200000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin priority pick: first set request at or above pointer, with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to act on the grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               any_req
);

  // Walk the requests starting from the pointer; the first hit wins.
  always_comb begin : pick
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(pointer) + i) % NUM_REQ;
      if (!any_req && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx[IDW-1:0];
        any_req    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART_TX among NUM_REQ byte requesters (optional watchdog: UART_TX_ARB_TIMEOUT_EN).
// Latency: req_ready in the grant cycle, tx_start one cycle later; next grant one cycle after tx_done.
// Backpressure: req_ready is only offered in IDLE with enable=1; data/parity held stable until tx_done.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int IDW            = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_parity_sel,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      uart_tx_start,
  output logic [DATA_W-1:0]         uart_d_in,
  output logic                      uart_parity_sel,
  input  logic                      uart_tx_done,
  output logic                      busy,
  output logic [IDW-1:0]            grant_id,
  output logic                      frame_done,
  output logic                      timeout_err
);

  state_t              state_q, state_d;
  logic [IDW-1:0]      ptr_q;
  logic [IDW-1:0]      grant_id_q;
  logic [DATA_W-1:0]   d_q;
  logic                par_q;
  logic                capture;
  logic                timeout_hit;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDW-1:0]      arb_idx;
  logic                arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .req       (req_valid),
    .pointer   (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;

  // Watchdog: cleared while in START so it reads 0 on the first BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset || state_q == START) tmo_cnt_q <= '0;
    else if (state_q == BUSY)      tmo_cnt_q <= tmo_cnt_q + 32'd1;
  end

  assign timeout_hit = (state_q == BUSY) && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog not built; parameter kept so both builds share one interface.
  localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Next-state and handshake outputs; everything is forced quiet while reset is high.
  always_comb begin
    state_d       = state_q;
    req_ready     = '0;
    uart_tx_start = 1'b0;
    frame_done    = 1'b0;
    timeout_err   = 1'b0;
    capture       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && arb_any) begin
          req_ready = arb_grant;
          capture   = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        uart_tx_start = 1'b1;
        state_d       = BUSY;
      end
      BUSY: begin
        if (uart_tx_done) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end else if (timeout_hit) begin
          timeout_err = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      req_ready     = '0;
      uart_tx_start = 1'b0;
      frame_done    = 1'b0;
      timeout_err   = 1'b0;
      capture       = 1'b0;
      state_d       = IDLE;
    end
  end

  // State, pointer and the frame payload that must stay stable until tx_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      d_q        <= '0;
      par_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        d_q        <= req_data[arb_idx*DATA_W +: DATA_W];
        par_q      <= req_parity_sel[arb_idx];
        grant_id_q <= arb_idx;
        ptr_q      <= (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
      end
    end
  end

  assign busy            = (state_q != IDLE);
  assign grant_id        = grant_id_q;
  assign uart_d_in       = d_q;
  assign uart_parity_sel = par_q;

endmodule
